// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: issue/query, ALU, load and register-file write signals of the writeback arbiter
interface regfile_wb_arbiter_if;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_din;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_din;
   logic        wen;
   logic [4:0]  rd;
   logic [31:0] din;
   logic        idle;

   modport master (
      output iss_valid, iss_rd, rs1, rs2, alu_valid, alu_rd, alu_din, mem_valid, mem_rd, mem_din,
      input  hazard, mem_ready, wen, rd, din, idle
   );

   modport slave (
      input  iss_valid, iss_rd, rs1, rs2, alu_valid, alu_rd, alu_din, mem_valid, mem_rd, mem_din,
      output hazard, mem_ready, wen, rd, din, idle
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: busy scoreboard plus ALU-first writeback arbiter with a 2-entry load FIFO
module regfile_wb_arbiter (
   input logic                clk,
   input logic                rst,
   regfile_wb_arbiter_if.slave bus
);
   logic [4:0]  q_rd  [2];
   logic [31:0] q_din [2];
   logic        rp;
   logic        wp;
   logic [1:0]  cnt;
   logic [31:1] busy;
   logic [31:0] busy_all;
   logic [31:0] busy_nxt;
   logic        push;
   logic        pop;
   logic        sel;
   logic        nxt_wen;
   logic [4:0]  nxt_rd;
   logic [31:0] nxt_din;

   // bit 0 is hard-wired clear so x0 never reports a hazard
   assign busy_all      = {busy, 1'b0};
   assign bus.hazard    = busy_all[bus.rs1] | busy_all[bus.rs2];
   assign bus.mem_ready = cnt != 2'd2;
   assign bus.idle      = (cnt == 2'd0) & ~|busy;
   assign push          = bus.mem_valid & bus.mem_ready;
   assign pop           = ~bus.alu_valid & (cnt != 2'd0);
   assign sel           = bus.alu_valid | pop;
   assign nxt_rd        = bus.alu_valid ? bus.alu_rd : q_rd[rp];
   assign nxt_din       = bus.alu_valid ? bus.alu_din : q_din[rp];
   assign nxt_wen       = sel & (nxt_rd != 5'd0);

   // clear the register being written, then let a same-edge issue re-mark it busy
   always_comb begin
      busy_nxt = busy_all;
      if (nxt_wen) busy_nxt[nxt_rd] = 1'b0;
      if (bus.iss_valid) busy_nxt[bus.iss_rd] = 1'b1;
   end

   // busy scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else busy <= busy_nxt[31:1];
   end

   // load FIFO; only stored entries are poppable, so a fresh load waits a cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_rd[0]  <= '0;
         q_rd[1]  <= '0;
         q_din[0] <= '0;
         q_din[1] <= '0;
         rp       <= 1'b0;
         wp       <= 1'b0;
         cnt      <= 2'd0;
      end else begin
         if (push) begin
            q_rd[wp]  <= bus.mem_rd;
            q_din[wp] <= bus.mem_din;
            wp        <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // registered write port; address and data hold when nothing is written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.wen <= 1'b0;
         bus.rd  <= '0;
         bus.din <= '0;
      end else begin
         bus.wen <= nxt_wen;
         if (sel) begin
            bus.rd  <= nxt_rd;
            bus.din <= nxt_din;
         end
      end
   end
endmodule
